// File: rtl/intalu_issue_stage.sv
// In-order integer-ALU issue stage: circular instruction FIFO, 32-entry
// RAW/WAW register scoreboard and a registered issue slot toward the ALU.
module intalu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enq,
    input  logic [XLEN-1:0] data_in,
    output logic            full,
    output logic            empty,
    output logic            issue_valid,
    output logic [XLEN-1:0] issue_instr,
    input  logic            fu_ready,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush
);
    localparam logic [6:0]     OP_REG   = 7'b0110011;
    localparam logic [6:0]     OP_IMM   = 7'b0010011;
    localparam logic [6:0]     OP_LUI   = 7'b0110111;
    localparam logic [6:0]     OP_AUIPC = 7'b0010111;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } dec_t;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      busy, busy_next;
    logic [XLEN-1:0]  head;
    dec_t             hd;
    logic             src_stall, waw_stall, slot_free, slot_xfer, do_issue, do_enq;

    // Occupancy flags come only from the count, never from pointer compare.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Decode the FIFO head; unknown opcodes conservatively read rs1 and rs2.
    always_comb begin
        head       = mem[rd_ptr];
        hd.rd      = head[11:7];
        hd.rs1     = head[19:15];
        hd.rs2     = head[24:20];
        hd.use_rs1 = 1'b1;
        hd.use_rs2 = 1'b1;
        case (head[6:0])
            OP_LUI, OP_AUIPC: begin
                hd.use_rs1 = 1'b0;
                hd.use_rs2 = 1'b0;
            end
            OP_IMM:  hd.use_rs2 = 1'b0;
            OP_REG:  hd.use_rs2 = 1'b1;
            default: hd.use_rs2 = 1'b1;
        endcase
    end

    // x0 is never busy as a source; busy[0] is never set so WAW on x0 is free.
    assign src_stall = (hd.use_rs1 && (hd.rs1 != 5'd0) && busy[hd.rs1]) ||
                       (hd.use_rs2 && (hd.rs2 != 5'd0) && busy[hd.rs2]);
    assign waw_stall = busy[hd.rd];
    assign slot_free = !issue_valid || fu_ready;
    assign slot_xfer = issue_valid && fu_ready;
    assign do_issue  = !empty && !src_stall && !waw_stall && slot_free;
    assign do_enq    = enq && !full;

    // Scoreboard next state: writeback clears first so a same-rd issue set wins.
    always_comb begin
        busy_next = busy;
        if (wb_valid && (wb_rd != 5'd0))
            busy_next[wb_rd] = 1'b0;
        if (do_issue && (hd.rd != 5'd0))
            busy_next[hd.rd] = 1'b1;
    end

    // Storage array; contents beyond the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_enq && !flush)
            mem[wr_ptr] <= data_in;
    end

    // FIFO pointers and occupancy count; flush returns to the reset state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_issue)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_enq, do_issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Register scoreboard update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else if (flush)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // Issue slot: load a hazard-free head, else empty the slot once it transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_instr <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
            issue_instr <= '0;
        end else if (do_issue) begin
            issue_valid <= 1'b1;
            issue_instr <= head;
        end else if (slot_xfer) begin
            issue_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_intalu_issue_stage.sv
// Directed bench for intalu_issue_stage with an in-order scoreboard of
// accepted instructions, checked whenever the issue slot transfers.
module tb_intalu_issue_stage;
    logic        clk = 1'b0;
    logic        reset, enq, fu_ready, wb_valid, flush;
    logic [31:0] data_in;
    logic [4:0]  wb_rd;
    logic        full, empty, issue_valid;
    logic [31:0] issue_instr;

    int          checks = 0;
    int          errors = 0;
    int          n_xfer = 0;
    logic        push_ok = 1'b1;
    logic [31:0] sbq[$];

    intalu_issue_stage #(.XLEN(32), .DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .enq(enq), .data_in(data_in),
        .full(full), .empty(empty), .issue_valid(issue_valid),
        .issue_instr(issue_instr), .fu_ready(fu_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: scoreboard bookkeeping at negedge, inputs change 1ns after posedge.
    task automatic tick();
        @(negedge clk);
        if (enq && push_ok) sbq.push_back(data_in);
        if (issue_valid && fu_ready) begin
            n_xfer++;
            chk1("xfer_expected", sbq.size() != 0, 1'b1);
            if (sbq.size() != 0) chk32("issue_order", issue_instr, sbq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1; wb_rd = rd;
        tick();
        wb_valid = 1'b0; wb_rd = 5'd0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        enq = 1'b0; fu_ready = 1'b1;
        while (!(empty && !issue_valid) && n < 40) begin
            tick();
            n++;
        end
        chk1({tag, "_drained"}, empty && !issue_valid, 1'b1);
        chk32({tag, "_sb_left"}, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int n0, mcnt;
        logic mslot, can;

        // 1) reset with enq held, then single-instruction latency
        reset = 1'b1; enq = 1'b1; data_in = addi(5'd0, 5'd0, 12'd7);
        fu_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0; push_ok = 1'b0;
        tick(); tick();
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_full", full, 1'b0);
        chk1("rst_valid", issue_valid, 1'b0);
        chk32("rst_instr", issue_instr, 32'd0);
        reset = 1'b0; push_ok = 1'b1;
        data_in = addi(5'd0, 5'd0, 12'd5);
        tick();
        enq = 1'b0;
        chk1("lat_edge1_valid", issue_valid, 1'b0);
        chk1("lat_edge1_empty", empty, 1'b0);
        tick();
        chk1("lat_edge2_valid", issue_valid, 1'b1);
        chk32("lat_edge2_instr", issue_instr, addi(5'd0, 5'd0, 12'd5));
        chk1("lat_edge2_empty", empty, 1'b1);
        drain("t1");

        // 2) fill behind an occupied slot, drop while full even with a dequeue
        n0 = n_xfer;
        enq = 1'b1; data_in = addi(5'd0, 5'd0, 12'd9);
        tick();
        enq = 1'b0; fu_ready = 1'b0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            enq = 1'b1; data_in = addi(5'd0, 5'd0, 12'(k));
            tick();
            chk1($sformatf("fill_full_%0d", k), full, k == 4);
        end
        push_ok = 1'b0; fu_ready = 1'b1; data_in = addi(5'd0, 5'd0, 12'd99);
        tick();
        push_ok = 1'b1; enq = 1'b0;
        chk1("drop_full_after", full, 1'b0);
        chk32("drop_slot_instr", issue_instr, addi(5'd0, 5'd0, 12'd1));
        drain("t2");
        chk32("fill_xfer_count", 32'(n_xfer - n0), 32'd5);

        // 3) RAW stall on x5 released the edge after writeback
        enq = 1'b1; data_in = 32'h00100293;
        tick();
        data_in = 32'h00528333;
        tick();
        enq = 1'b0;
        chk32("raw_first_instr", issue_instr, 32'h00100293);
        tick();
        chk1("raw_stall_a", issue_valid, 1'b0);
        tick(); tick();
        chk1("raw_stall_b", issue_valid, 1'b0);
        chk1("raw_stall_nonempty", empty, 1'b0);
        wb(5'd5);
        chk1("raw_no_bypass", issue_valid, 1'b0);
        tick();
        chk1("raw_release_valid", issue_valid, 1'b1);
        chk32("raw_release_instr", issue_instr, 32'h00528333);
        drain("t3");

        // 4) issue-set beats same-edge wb clear; lui ignores busy x5; WAW stall
        wb(5'd6);
        enq = 1'b1; data_in = addi(5'd5, 5'd0, 12'd2);
        tick();
        data_in = 32'h000073B7; wb_valid = 1'b1; wb_rd = 5'd5;
        tick();
        wb_valid = 1'b0; wb_rd = 5'd0; data_in = addi(5'd8, 5'd5, 12'd0);
        tick();
        enq = 1'b0;
        chk1("lui_unstalled_valid", issue_valid, 1'b1);
        chk32("lui_unstalled_instr", issue_instr, 32'h000073B7);
        tick();
        chk1("setwins_stall_a", issue_valid, 1'b0);
        tick();
        chk1("setwins_stall_b", issue_valid, 1'b0);
        wb(5'd5);
        chk1("setwins_no_bypass", issue_valid, 1'b0);
        tick();
        chk32("setwins_release", issue_instr, addi(5'd8, 5'd5, 12'd0));
        enq = 1'b1; data_in = lui(5'd7, 20'd1);
        tick();
        enq = 1'b0;
        tick();
        chk1("waw_stall_a", issue_valid, 1'b0);
        tick();
        chk1("waw_stall_b", issue_valid, 1'b0);
        wb(5'd7);
        chk1("waw_no_bypass", issue_valid, 1'b0);
        tick();
        chk1("waw_release_valid", issue_valid, 1'b1);
        chk32("waw_release_instr", issue_instr, lui(5'd7, 20'd1));
        drain("t4");

        // 5) pointer wrap with fu_ready toggling; occupancy modelled here
        mcnt = 0; mslot = 1'b0;
        for (int k = 0; k < 10; k++) begin
            enq = 1'b1; data_in = addi(5'd0, 5'd0, 12'(20 + k));
            fu_ready = (k % 2 == 0);
            push_ok = (mcnt < 4);
            can = (mcnt > 0) && (!mslot || fu_ready);
            tick();
            mcnt = mcnt + (push_ok ? 1 : 0) - (can ? 1 : 0);
            mslot = can ? 1'b1 : ((mslot && fu_ready) ? 1'b0 : mslot);
            chk1($sformatf("wrap_full_%0d", k), full, mcnt == 4);
            chk1($sformatf("wrap_empty_%0d", k), empty, mcnt == 0);
        end
        push_ok = 1'b1;
        drain("t5");

        // 6) flush with 3 queued, slot valid, x5 busy; simultaneous enq discarded
        fu_ready = 1'b0;
        enq = 1'b1; data_in = addi(5'd5, 5'd0, 12'd3);
        tick();
        data_in = addi(5'd0, 5'd0, 12'd31);
        tick();
        data_in = addi(5'd0, 5'd0, 12'd32);
        tick();
        data_in = addi(5'd0, 5'd0, 12'd33);
        tick();
        chk1("preflush_valid", issue_valid, 1'b1);
        chk1("preflush_empty", empty, 1'b0);
        flush = 1'b1; push_ok = 1'b0; data_in = addi(5'd0, 5'd0, 12'd34);
        tick();
        flush = 1'b0; enq = 1'b0; push_ok = 1'b1;
        sbq.delete();
        chk1("flush_empty", empty, 1'b1);
        chk1("flush_full", full, 1'b0);
        chk1("flush_valid", issue_valid, 1'b0);
        chk32("flush_instr", issue_instr, 32'd0);
        fu_ready = 1'b1;
        enq = 1'b1; data_in = add(5'd9, 5'd7, 5'd8);
        tick();
        data_in = add(5'd6, 5'd5, 5'd5);
        tick();
        enq = 1'b0;
        chk1("postflush_valid", issue_valid, 1'b1);
        chk32("postflush_busy78", issue_instr, add(5'd9, 5'd7, 5'd8));
        tick();
        chk32("postflush_busy5", issue_instr, add(5'd6, 5'd5, 5'd5));
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
